// File: rtl/systolic_array_os_rect_pkg.sv
// systolic_array_os_rect_pkg: shared state type for the output-stationary systolic array.
package systolic_array_os_rect_pkg;
  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} systolic_os_state_e;
endpackage

// File: rtl/systolic_array_os_rect_if.sv
// systolic_array_os_rect_if: job control, operand stream and result stream of the systolic array.
interface systolic_array_os_rect_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 256
);
  logic                          start;
  logic [$clog2(K_MAX+1)-1:0]    k_len;
  logic                          busy;
  logic                          in_valid;
  logic                          in_ready;
  logic [ROWS*DATA_WIDTH-1:0]    in_a;
  logic [COLS*DATA_WIDTH-1:0]    in_b;
  logic                          out_valid;
  logic                          out_ready;
  logic [COLS*ACC_WIDTH-1:0]     out_data;
  logic                          out_last;
  modport slave (input start, k_len, in_valid, in_a, in_b, out_ready,
                 output busy, in_ready, out_valid, out_data, out_last);
  modport master (output start, k_len, in_valid, in_a, in_b, out_ready,
                  input busy, in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/systolic_array_os_rect_input_skew.sv
// systolic_input_skew: delays lane i (data + valid) by i cycles to form the systolic wavefront.
module systolic_input_skew #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LANES*WIDTH-1:0] d_i,
  input  logic                   v_i,
  output logic [LANES*WIDTH-1:0] d_o,
  output logic [LANES-1:0]       v_o
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    if (l == 0) begin : g_pass
      assign d_o[WIDTH-1:0] = d_i[WIDTH-1:0];
      assign v_o[0] = v_i;
    end else begin : g_dly
      logic [WIDTH-1:0] d_q [l];
      logic [l-1:0]     v_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int j = 0; j < l; j++) d_q[j] <= '0;
          v_q <= '0;
        end else begin
          d_q[0] <= d_i[l*WIDTH +: WIDTH];
          v_q[0] <= v_i;
          for (int j = 1; j < l; j++) begin
            d_q[j] <= d_q[j-1];
            v_q[j] <= v_q[j-1];
          end
        end
      assign d_o[l*WIDTH +: WIDTH] = d_q[l-1];
      assign v_o[l] = v_q[l-1];
    end
  end
endmodule

// File: rtl/systolic_array_os_rect.sv
// systolic_array_os_rect: output-stationary ROWS x COLS integer systolic array with skew, K controller, row drain.
// Define SYSTOLIC_OS_RELU_EN to clamp negative drained elements to zero.
module systolic_array_os_rect
  import systolic_array_os_rect_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int K_MAX      = 256
) (
  input logic core_clk,
  input logic resetn,
  systolic_array_os_rect_if.slave bus
);
  localparam int FLUSH_CYCLES = ROWS + COLS - 1;
  localparam int KW = $clog2(K_MAX + 1);
  localparam int CW = $clog2(ROWS + COLS + 1);
  systolic_os_state_e state_q;
  logic [KW-1:0] beats_q;
  logic [CW-1:0] cnt_q;
  logic fire, clr, shift;
  logic [ROWS*DATA_WIDTH-1:0] sa_d;
  logic [ROWS-1:0]            sa_v;
  logic [COLS*DATA_WIDTH-1:0] sb_d;
  logic [COLS-1:0]            sb_v;
  logic signed [DATA_WIDTH-1:0] a_q [ROWS][COLS], b_q [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] a_w [ROWS][COLS], b_w [ROWS][COLS];
  logic                         av_q [ROWS][COLS], bv_q [ROWS][COLS];
  logic                         av_w [ROWS][COLS], bv_w [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  acc_q [ROWS][COLS];
  assign fire          = bus.in_valid && bus.in_ready;
  assign clr           = state_q == IDLE && bus.start;
  assign shift         = state_q == DRAIN && bus.out_ready;
  assign bus.busy      = state_q != IDLE;
  assign bus.in_ready  = state_q == FEED;
  assign bus.out_valid = state_q == DRAIN;
  assign bus.out_last  = state_q == DRAIN && cnt_q == CW'(ROWS - 1);
  always_ff @(posedge core_clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      beats_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= bus.k_len == '0 ? DRAIN : FEED;
          beats_q <= bus.k_len;
          cnt_q   <= '0;
        end
        FEED: if (fire) begin
          beats_q <= beats_q - KW'(1);
          if (beats_q == KW'(1)) state_q <= FLUSH;
        end
        FLUSH: begin
          cnt_q <= cnt_q == CW'(FLUSH_CYCLES - 1) ? '0 : cnt_q + CW'(1);
          if (cnt_q == CW'(FLUSH_CYCLES - 1)) state_q <= DRAIN;
        end
        DRAIN: if (bus.out_ready) begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(ROWS - 1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  // Cycles without an accepted beat inject invalid bubbles into the wavefront
  systolic_input_skew #(.WIDTH(DATA_WIDTH), .LANES(ROWS)) u_skew_a (
    .clk(core_clk), .rst_n(resetn), .d_i(bus.in_a), .v_i(fire), .d_o(sa_d), .v_o(sa_v));
  systolic_input_skew #(.WIDTH(DATA_WIDTH), .LANES(COLS)) u_skew_b (
    .clk(core_clk), .rst_n(resetn), .d_i(bus.in_b), .v_i(fire), .d_o(sb_d), .v_o(sb_v));
  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]    acc_nx;
      if (c == 0) begin : g_ea
        assign a_w[r][c]  = sa_d[r*DATA_WIDTH +: DATA_WIDTH];
        assign av_w[r][c] = sa_v[r];
      end else begin : g_fa
        assign a_w[r][c]  = a_q[r][c-1];
        assign av_w[r][c] = av_q[r][c-1];
      end
      if (r == 0) begin : g_eb
        assign b_w[r][c]  = sb_d[c*DATA_WIDTH +: DATA_WIDTH];
        assign bv_w[r][c] = sb_v[c];
      end else begin : g_fb
        assign b_w[r][c]  = b_q[r-1][c];
        assign bv_w[r][c] = bv_q[r-1][c];
      end
      if (r == ROWS - 1) begin : g_last
        assign acc_nx = '0;
      end else begin : g_up
        assign acc_nx = acc_q[r+1][c];
      end
      assign prod = a_w[r][c] * b_w[r][c];
      always_ff @(posedge core_clk or negedge resetn)
        if (!resetn) begin
          a_q[r][c]   <= '0;
          b_q[r][c]   <= '0;
          av_q[r][c]  <= 1'b0;
          bv_q[r][c]  <= 1'b0;
          acc_q[r][c] <= '0;
        end else begin
          a_q[r][c]   <= a_w[r][c];
          b_q[r][c]   <= b_w[r][c];
          av_q[r][c]  <= av_w[r][c];
          bv_q[r][c]  <= bv_w[r][c];
          acc_q[r][c] <= clr ? '0 : shift ? acc_nx :
                         (av_w[r][c] && bv_w[r][c]) ? acc_q[r][c] + ACC_WIDTH'(prod) : acc_q[r][c];
        end
    end
  end
  for (genvar c = 0; c < COLS; c++) begin : g_out
`ifdef SYSTOLIC_OS_RELU_EN
    assign bus.out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[0][c][ACC_WIDTH-1] ? '0 : acc_q[0][c];
`else
    assign bus.out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_q[0][c];
`endif
  end
endmodule

// File: tb/tb_systolic_array_os_rect.sv
// tb_systolic_array_os_rect: directed jobs on a 4x4 and a 2x3 array, checked against a matrix-product model.
module tb_systolic_array_os_rect;
  localparam int DW = 16, AW = 40, KM = 256;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  systolic_array_os_rect_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(4), .COLS(4), .K_MAX(KM)) if4 ();
  systolic_array_os_rect_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(2), .COLS(3), .K_MAX(KM)) if23 ();
  systolic_array_os_rect #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(4), .COLS(4), .K_MAX(KM)) dut4 (
    .core_clk(clk), .resetn(rst_n), .bus(if4.slave));
  systolic_array_os_rect #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ROWS(2), .COLS(3), .K_MAX(KM)) dut23 (
    .core_clk(clk), .resetn(rst_n), .bus(if23.slave));
  logic st [2], iv [2], ordy [2];
  logic [8:0] kl;
  logic [63:0] ia, ib;
  logic bsy [2], ird [2], ov [2], ol [2];
  logic [159:0] od [2];
  assign if4.start = st[0];     assign if23.start = st[1];
  assign if4.k_len = kl;        assign if23.k_len = kl;
  assign if4.in_valid = iv[0];  assign if23.in_valid = iv[1];
  assign if4.in_a = ia;         assign if23.in_a = ia[31:0];
  assign if4.in_b = ib;         assign if23.in_b = ib[47:0];
  assign if4.out_ready = ordy[0]; assign if23.out_ready = ordy[1];
  assign bsy[0] = if4.busy;     assign bsy[1] = if23.busy;
  assign ird[0] = if4.in_ready; assign ird[1] = if23.in_ready;
  assign ov[0] = if4.out_valid; assign ov[1] = if23.out_valid;
  assign ol[0] = if4.out_last;  assign ol[1] = if23.out_last;
  assign od[0] = if4.out_data;  assign od[1] = {40'd0, if23.out_data};
  int checks = 0, failures = 0;
  int ma [4][8], mb [8][4];
  logic [159:0] q0 [$], q1 [$];
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask
  // C row r = sum over k of A[r][k]*B[k][c], wrapped to the accumulator width
  function automatic logic [159:0] mrow(input int nc, input int r, input int k);
    logic [159:0] v;
    longint s;
    logic [39:0] e;
    v = '0;
    for (int c = 0; c < nc; c++) begin
      s = 0;
      for (int i = 0; i < k; i++) s += longint'(ma[r][i]) * longint'(mb[i][c]);
      e = s[39:0];
`ifdef SYSTOLIC_OS_RELU_EN
      if (e[39]) e = '0;
`endif
      v[c*40 +: 40] = e;
    end
    return v;
  endfunction
  int rowi [2] = '{0, 0};
  bit held [2] = '{0, 0};
  logic [159:0] hold [2];
  int nr;
  logic [159:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      rowi = '{0, 0};
      held = '{0, 0};
    end else for (int s = 0; s < 2; s++) begin
      nr = s == 0 ? 4 : 2;
      if (held[s] && ov[s]) chk("stable", od[s], hold[s]);
      held[s] = ov[s] && !ordy[s];
      hold[s] = od[s];
      if (ov[s] && ordy[s]) begin
        if ((s == 0 ? q0.size() : q1.size()) == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_row dut=%0d act=%0h exp=none", s, od[s]);
        end else begin
          e = s == 0 ? q0.pop_front() : q1.pop_front();
          chk(s == 0 ? "row4x4" : "row2x3", od[s], e);
        end
        chk("out_last", 160'(ol[s]), 160'(rowi[s] == nr - 1));
        rowi[s] = rowi[s] == nr - 1 ? 0 : rowi[s] + 1;
      end
    end
  end
  task automatic job(input int s, input int k, input bit tog, input int stall, input bit lit,
                     input int abort_at, input bit pulse);
    int i, cyc;
    bit fire;
    if (!lit) for (int r = 0; r < (s == 0 ? 4 : 2); r++)
      if (s == 0) q0.push_back(mrow(4, r, k)); else q1.push_back(mrow(3, r, k));
    st[s] = 1'b1; kl = 9'(k);
    @(posedge clk); #1 st[s] = 1'b0;
    chk("busy_after_start", 160'(bsy[s]), 160'(1));
    i = 0; cyc = 0;
    while (i < k && cyc < 200) begin
      iv[s] = tog ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
      ia = '0; ib = '0;
      for (int r = 0; r < 4; r++) ia[r*16 +: 16] = 16'(ma[r][i]);
      for (int c = 0; c < 4; c++) ib[c*16 +: 16] = 16'(mb[i][c]);
      if (pulse && cyc == 1) begin st[s] = 1'b1; kl = 9'd0; end
      @(negedge clk);
      if (abort_at > 0 && i == abort_at) begin
        rst_n = 1'b0; #1;
        chk("abort_busy", 160'(bsy[s]), 160'(0));
        chk("abort_in_ready", 160'(ird[s]), 160'(0));
        chk("abort_out_valid", 160'(ov[s]), 160'(0));
        chk("abort_out_data", od[s], '0);
        iv[s] = 1'b0; q0.delete(); q1.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        return;
      end
      fire = iv[s] && ird[s];
      @(posedge clk); #1 st[s] = 1'b0;
      if (fire) i++;
      cyc++;
    end
    if (i < k) begin checks++; failures++; $display("FAIL feed_timeout act=%0d exp=%0d", i, k); end
    iv[s] = 1'b0; cyc = 0;
    while (bsy[s] && cyc < 500) begin
      ordy[s] = stall == 0 || (cyc % (stall + 1) == stall);
      @(negedge clk);
      chk("no_in_ready", 160'(ird[s]), 160'(0));
      @(posedge clk); #1;
      cyc++;
    end
    ordy[s] = 1'b0;
    chk("job_done", 160'(bsy[s]), 160'(0));
    chk("rows_drained", 160'(s == 0 ? q0.size() : q1.size()), 160'(0));
  endtask
  initial begin
    st = '{0, 0}; iv = '{0, 0}; ordy = '{0, 0}; kl = '0; ia = '0; ib = '0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("rst_busy", 160'(bsy[s]), 160'(0));
      chk("rst_in_ready", 160'(ird[s]), 160'(0));
      chk("rst_out_valid", 160'(ov[s]), 160'(0));
      chk("rst_out_last", 160'(ol[s]), 160'(0));
      chk("rst_out_data", od[s], '0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      ma[r][c] = r == c ? 1 : 0;
      mb[r][c] = r * 4 + c + 1;
    end
    chk("model_identity", mrow(4, 2, 4), {40'd12, 40'd11, 40'd10, 40'd9});
    job(0, 4, 0, 0, 0, 0, 0);
    job(0, 4, 1, 3, 0, 0, 0);
    job(0, 4, 0, 0, 0, 0, 1);
    job(0, 0, 0, 1, 0, 0, 0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin
      ma[r][c] = -32768;
      mb[r][c] = -32768;
    end
    for (int r = 0; r < 4; r++) q0.push_back({4{40'h01_0000_0000}});
    job(0, 4, 0, 0, 1, 0, 0);
    for (int r = 0; r < 4; r++) for (int i = 0; i < 8; i++) begin
      ma[r][i] = (r - i) * 300 + 7;
      mb[i][r] = i * r - 5 * i + 1000 * (r - 2);
    end
    job(0, 6, 1, 2, 0, 0, 0);
    ma[0][0] = 1; ma[0][1] = 2; ma[0][2] = 3;
    ma[1][0] = 4; ma[1][1] = 5; ma[1][2] = 6;
    mb[0][0] = 1; mb[0][1] = 0; mb[0][2] = 2;
    mb[1][0] = 0; mb[1][1] = 1; mb[1][2] = 0;
    mb[2][0] = 3; mb[2][1] = 0; mb[2][2] = 1;
    mb[0][3] = 0; mb[1][3] = 0; mb[2][3] = 0;
    chk("model_test2", mrow(3, 1, 3), {40'd0, 40'd14, 40'd5, 40'd22});
    job(1, 3, 0, 0, 0, 2, 0);
    q1.push_back({40'd0, 40'd5, 40'd2, 40'd10});
    q1.push_back({40'd0, 40'd14, 40'd5, 40'd22});
    job(1, 3, 0, 1, 1, 0, 0);
    job(1, 3, 1, 2, 0, 0, 0);
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
